// File: rtl/bidir_shift_register_array.sv
// rtl/bidir_shift_register_array.sv - bidirectional shift register array with valid tracking, parallel load and flush
module bidir_shift_register_array #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         dir,
    input  logic [BIT_WIDTH-1:0]         in,
    input  logic                         in_valid,
    input  logic                         load,
    input  logic [DEPTH*BIT_WIDTH-1:0]   load_data,
    input  logic                         clear,
    output logic [BIT_WIDTH-1:0]         out,
    output logic                         out_valid,
    output logic [DEPTH*BIT_WIDTH-1:0]   taps,
    output logic [$clog2(DEPTH+1)-1:0]   fill_count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [BIT_WIDTH-1:0] data_q [DEPTH];
    logic [BIT_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_d;
    logic [CW-1:0]        fill_q;
    logic [CW-1:0]        fill_d;
    logic                 exit_valid;

    // Flag of the stage that a shift in the current direction would discard.
    assign exit_valid = dir ? valid_q[0] : valid_q[DEPTH-1];

    // Next-state: clear beats load beats shift; otherwise everything holds.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fill_d  = fill_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
            fill_d  = '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = load_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
            valid_d = '1;
            fill_d  = CW'(DEPTH);
        end else if (enable) begin
            if (!dir) begin
                data_d[0]  = in;
                valid_d[0] = in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    data_d[i]  = data_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end else begin
                data_d[DEPTH-1]  = in;
                valid_d[DEPTH-1] = in_valid;
                for (int i = 0; i < DEPTH - 1; i++) begin
                    data_d[i]  = data_q[i+1];
                    valid_d[i] = valid_q[i+1];
                end
            end
            // Occupancy moves only when the entering and leaving flags differ,
            // so it tracks popcount of the flags and can never wrap.
            if (in_valid && !exit_valid) begin
                fill_d = fill_q + CW'(1);
            end else if (!in_valid && exit_valid) begin
                fill_d = fill_q - CW'(1);
            end
        end
    end

    // State registers; reset empties the array immediately, independent of clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            fill_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs follow state and dir combinationally, so a dir change re-selects the exit stage at once.
    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            taps[i*BIT_WIDTH +: BIT_WIDTH] = data_q[i];
        end
        out        = dir ? data_q[0] : data_q[DEPTH-1];
        out_valid  = exit_valid;
        fill_count = fill_q;
    end

endmodule

// File: tb/tb_bidir_shift_register_array.sv
// tb/tb_bidir_shift_register_array.sv - randomized and directed self-checking bench for bidir_shift_register_array
module tb_bidir_shift_register_array;

    localparam int W = 8;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          dir;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          load;
    logic [D*W-1:0] load_data;
    logic          clear;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [D*W-1:0] taps;
    logic [3:0]    fill_count;

    int total = 0;
    int bad   = 0;

    // Reference: queue element i is stage i, stored as {valid, data}.
    logic [W:0] mq [$];

    logic [W-1:0] seq [8] = '{8'h6F, 8'h7E, 8'h0A, 8'h3B, 8'h2C, 8'h99, 8'h05, 8'h33};

    bidir_shift_register_array #(.BIT_WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .dir        (dir),
        .in         (din),
        .in_valid   (din_valid),
        .load       (load),
        .load_data  (load_data),
        .clear      (clear),
        .out        (dout),
        .out_valid  (dout_valid),
        .taps       (taps),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < D; i++) mq.push_back('0);
    endtask

    task automatic model_step();
        logic [W:0] dropped;
        if (clear) begin
            model_reset();
        end else if (load) begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back({1'b1, load_data[i*W +: W]});
        end else if (enable) begin
            if (!dir) begin
                mq.push_front({din_valid, din});
                dropped = mq.pop_back();
            end else begin
                mq.push_back({din_valid, din});
                dropped = mq.pop_front();
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [D*W-1:0] et;
        logic [W:0]     ex;
        int             cnt;
        et  = '0;
        cnt = 0;
        for (int i = 0; i < D; i++) begin
            et[i*W +: W] = mq[i][W-1:0];
            cnt += int'(mq[i][W]);
        end
        ex = dir ? mq[0] : mq[D-1];
        check_eq({tag, "_out"},  dout, ex[W-1:0]);
        check_eq({tag, "_ov"},   dout_valid, ex[W]);
        check_eq({tag, "_taps"}, taps, et);
        check_eq({tag, "_fill"}, fill_count, cnt);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        enable = 0; clear = 0; load = 0; din = '0; din_valid = 0;
    endtask

    initial begin
        logic [D*W-1:0] ld;
        reset_n = 0; dir = 0; load_data = '0;
        idle_inputs();
        model_reset();
        #12;
        compare_all("reset");
        check_eq("reset_fill", fill_count, 0);
        reset_n = 1;
        #1;

        // Serial stream, left shift
        for (int k = 1; k <= 16; k++) begin
            enable = 1; din = (k <= 8) ? seq[k-1] : 8'h00; din_valid = (k <= 8);
            tick("t030");
            check_eq("t030_out", dout, (k >= 8 && k <= 15) ? seq[k-8] : 8'h00);
            check_eq("t030_ov", dout_valid, (k >= 8 && k <= 15));
            check_eq("t030_fill", fill_count, (k <= 8) ? k : 16 - k);
        end

        // Same stream, right shift
        idle_inputs(); clear = 1; tick("t031_clr"); clear = 0;
        dir = 1;
        for (int k = 1; k <= 16; k++) begin
            enable = 1; din = (k <= 8) ? seq[k-1] : 8'h00; din_valid = (k <= 8);
            tick("t031");
            if (k == 1) check_eq("t031_tap7", taps[63:56], 8'h6F);
            check_eq("t031_out", dout, (k >= 8 && k <= 15) ? seq[k-8] : 8'h00);
            check_eq("t031_fill", fill_count, (k <= 8) ? k : 16 - k);
        end

        // Parallel load then partial drain, then direction flip
        idle_inputs(); dir = 0;
        load = 1; load_data = 64'h0706050403020100;
        tick("t032_ld"); load = 0;
        check_eq("t032_out0", dout, 8'h07);
        check_eq("t032_fill0", fill_count, 8);
        for (int j = 1; j <= 3; j++) begin
            enable = 1; din = 8'hFF; din_valid = 0;
            tick("t032");
            check_eq("t032_out", dout, 8'h07 - j);
            check_eq("t032_fill", fill_count, 8 - j);
        end
        enable = 0; dir = 1;
        #1;
        compare_all("t032_flip");
        check_eq("t032_flip_out", dout, 8'hFF);
        check_eq("t032_flip_ov", dout_valid, 0);

        // Fill four, reverse, drain
        idle_inputs(); dir = 0; clear = 1; tick("t033_clr"); clear = 0;
        for (int j = 1; j <= 4; j++) begin
            enable = 1; din = 8'hA0 + j; din_valid = 1;
            tick("t033_fill");
        end
        din = '0; din_valid = 0; dir = 1;
        #1;
        check_eq("t033_first", dout, 8'hA4);
        for (int j = 1; j <= 4; j++) begin
            tick("t033_drain");
            check_eq("t033_out", dout, (j <= 3) ? 8'hA4 - j : 8'h00);
            check_eq("t033_fill", fill_count, 4 - j);
        end

        // Clear wins over load and enable; idle holds
        idle_inputs();
        ld = {$urandom, $urandom};
        load = 1; load_data = ld; tick("t034_ld"); load = 0;
        for (int j = 0; j < 5; j++) begin
            din = $urandom; din_valid = j[0]; dir = j[1];
            tick("t034_hold");
            check_eq("t034_hold_taps", taps, ld);
        end
        clear = 1; load = 1; enable = 1; load_data = ~ld;
        tick("t034_prio");
        check_eq("t034_prio_taps", taps, 0);
        check_eq("t034_prio_fill", fill_count, 0);
        idle_inputs();
        for (int j = 0; j < 5; j++) begin
            din = $urandom; din_valid = 1;
            tick("t034_idle");
            check_eq("t034_idle_taps", taps, 0);
        end

        // Asynchronous reset between edges with full array
        idle_inputs(); dir = 0;
        load = 1; load_data = {$urandom, $urandom} | 64'h1; tick("t035_ld"); load = 0;
        #2 reset_n = 0;
        model_reset();
        #1;
        compare_all("t035_rst");
        check_eq("t035_taps", taps, 0);
        check_eq("t035_fill", fill_count, 0);
        #2 reset_n = 1;
        enable = 1; din = 8'hAA; din_valid = 1;
        tick("t035_in");
        din = '0; din_valid = 0;
        for (int j = 2; j <= D; j++) tick("t035_sh");
        check_eq("t035_out", dout, 8'hAA);
        check_eq("t035_ov", dout_valid, 1);

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            clear     = ($urandom_range(0, 31) == 0);
            load      = ($urandom_range(0, 15) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            din       = $urandom;
            din_valid = $urandom;
            load_data = {$urandom, $urandom};
            tick("rnd");
            if ($urandom_range(0, 9) == 0) begin
                dir = ~dir;
                #1;
                compare_all("rnd_dir");
            end
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 0;
                model_reset();
                #1;
                compare_all("rnd_rst");
                reset_n = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
